// File: rtl/binary2deg_pkg.sv
// Shared types, constants and the restoring-division step for the binary-to-degree converter.
// The step helpers are written for operands up to DIV_MAX_W bits (callers need IN_W+OUT_W <= DIV_MAX_W).
package binary2deg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DIVISOR_DEG = 90;
  localparam int unsigned DIV_MAX_W   = 64;

  // Counter width for a count of n steps; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Quotient bit of one restoring step: set when the shifted divisor fits.
  function automatic logic restore_take(input logic [DIV_MAX_W-1:0] rem,
                                        input logic [DIV_MAX_W-1:0] dvs);
    return rem >= dvs;
  endfunction

  // Partial remainder after one restoring step.
  function automatic logic [DIV_MAX_W-1:0] restore_rem(input logic [DIV_MAX_W-1:0] rem,
                                                       input logic [DIV_MAX_W-1:0] dvs);
    return restore_take(rem, dvs) ? rem - dvs : rem;
  endfunction

endpackage

// File: rtl/binary2deg_seq_div.sv
// Serial restoring divider: binary angle / divisor, one quotient bit per cycle, MSB first,
// with valid/ready handshakes on both sides and a passthrough channel tag.
module binary2deg_seq_div
  import binary2deg_pkg::*;
#(
  parameter int unsigned IN_W    = 22,
  parameter int unsigned OUT_W   = 14,
  parameter int unsigned DIVISOR = DIVISOR_DEG,
  parameter int unsigned TAG_W   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_binary,
  input  logic [IN_W-1:0]  i_divisor,
  input  logic             i_mode,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_deg,
  output logic [IN_W-1:0]  o_rem,
  output logic             o_ovf,
  output logic [TAG_W-1:0] o_tag
);

  localparam int unsigned W     = IN_W + OUT_W;
  localparam int unsigned CNT_W = cnt_width(OUT_W);

  state_e           state_q, state_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [OUT_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_d, valid_d, ovf_d;
  logic [OUT_W-1:0] deg_d;
  logic [IN_W-1:0]  rem_out_d;
  logic [TAG_W-1:0] tag_d;

  logic [IN_W-1:0]  div_sel_c;
  logic             take_c;
  logic [W-1:0]     rem_nxt_c;
  logic [OUT_W-1:0] quo_nxt_c;

  // Divisor selection and one restoring step on the current partial remainder.
  always_comb begin
    div_sel_c = i_mode ? i_divisor : IN_W'(DIVISOR);
    take_c    = restore_take(DIV_MAX_W'(rem_q), DIV_MAX_W'(dvs_q));
    rem_nxt_c = W'(restore_rem(DIV_MAX_W'(rem_q), DIV_MAX_W'(dvs_q)));
    quo_nxt_c = OUT_W'({quo_q, take_c});
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    ready_d   = o_ready;
    valid_d   = o_valid;
    deg_d     = o_deg;
    rem_out_d = o_rem;
    ovf_d     = o_ovf;
    tag_d     = o_tag;

    unique case (state_q)
      IDLE: begin
        if (i_valid && o_ready) begin
          tag_d   = i_tag;
          ready_d = 1'b0;
          if (div_sel_c == '0) begin
            deg_d     = '1;
            rem_out_d = i_binary;
            ovf_d     = 1'b1;
            valid_d   = 1'b1;
            state_d   = DONE;
          end else if (W'(i_binary) >= (W'(div_sel_c) << OUT_W)) begin
            deg_d     = '1;
            rem_out_d = '0;
            ovf_d     = 1'b1;
            valid_d   = 1'b1;
            state_d   = DONE;
          end else begin
            rem_d   = W'(i_binary);
            dvs_d   = W'(div_sel_c) << (OUT_W - 1);
            quo_d   = '0;
            cnt_d   = '0;
            state_d = CAL;
          end
        end
      end
      CAL: begin
        rem_d = rem_nxt_c;
        dvs_d = dvs_q >> 1;
        quo_d = quo_nxt_c;
        cnt_d = cnt_q + CNT_W'(1);
        // Remainder is below the divisor here, so it always fits the dividend width.
        if (cnt_q == CNT_W'(OUT_W - 1)) begin
          deg_d     = quo_nxt_c;
          rem_out_d = IN_W'(rem_nxt_c);
          ovf_d     = 1'b0;
          valid_d   = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_deg   <= '0;
      o_rem   <= '0;
      o_ovf   <= 1'b0;
      o_tag   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      o_ready <= ready_d;
      o_valid <= valid_d;
      o_deg   <= deg_d;
      o_rem   <= rem_out_d;
      o_ovf   <= ovf_d;
      o_tag   <= tag_d;
    end
  end

endmodule
